mod_sample_sched: RTL and testbench

- Sample scheduler between two 8-bit sample FIFOs (src0 = host stream, src1 = local test/beacon source) and the PWM modulator's FIFO-style input (sample/empty/read).
- Arbitrates per configurable mode and prefetches one sample.
- Holds the sample presented to the modulator stable for the whole PWM symbol.
- Optionally injects a mid-scale fill sample on underrun so the carrier never stops.

---
 rtl/mod_sample_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_mod_sample_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sample_sched.sv
// -----------------------------------------------------------------------------
// mod_sample_sched
//
// Purpose:
//   Schedules 8-bit samples from two sample FIFOs (src0 = host stream,
//   src1 = local test/beacon source) into the PWM modulator's FIFO-style
//   input. One sample is prefetched into "nxt" while the modulator works on
//   "cur". "cur" only changes when the modulator consumes, so the sample it
//   sees is stable for the whole PWM symbol. When no source can supply a
//   sample, a mid-scale fill sample can be injected so the carrier never
//   stops.
//
// Ports:
//   i_clk, i_rst_n       system clock, asynchronous active-low reset
//   i_enable             allow new fetches from the sources
//   i_mode               0=src0 only, 1=src1 only, 2=round-robin burst,
//                        3=fixed priority src0
//   i_fill_en            enable underrun fill
//   i_srcN_data          source FIFO read data, valid 1 cycle after read
//   i_srcN_empty         source FIFO empty
//   o_srcN_read          source FIFO read strobe
//   o_mod_sample         sample presented to the modulator ("cur")
//   o_mod_empty          no prefetched sample available
//   i_mod_read           modulator consume strobe
//   o_active_src         source of the last granted fetch
//   o_underrun_cnt       saturating count of inserted fill samples
//   o_busy               fetch in flight or prefetch valid
//
// States:
//   ST_IDLE    | waiting for an empty prefetch slot; arbitrates, issues the
//              | read strobe or inserts a fill sample
//   ST_CAPTURE | read issued last cycle; latch source data into nxt
// -----------------------------------------------------------------------------
module mod_sample_sched #(
    parameter int SAMPLE_W    = 8,
    parameter int BURST_LEN   = 16,
    parameter int IDLE_SAMPLE = 128,
    parameter int CNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [1:0]          i_mode,
    input  logic                i_fill_en,
    input  logic [SAMPLE_W-1:0] i_src0_data,
    input  logic                i_src0_empty,
    output logic                o_src0_read,
    input  logic [SAMPLE_W-1:0] i_src1_data,
    input  logic                i_src1_empty,
    output logic                o_src1_read,
    output logic [SAMPLE_W-1:0] o_mod_sample,
    output logic                o_mod_empty,
    input  logic                i_mod_read,
    output logic                o_active_src,
    output logic [CNT_W-1:0]    o_underrun_cnt,
    output logic                o_busy
);

    localparam int                  BC_W     = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0]     LP_BURST = BC_W'(BURST_LEN);
    localparam logic [SAMPLE_W-1:0] LP_IDLE  = SAMPLE_W'(IDLE_SAMPLE);

    localparam logic [1:0] MODE_SRC0 = 2'd0;
    localparam logic [1:0] MODE_SRC1 = 2'd1;
    localparam logic [1:0] MODE_RR   = 2'd2;
    localparam logic [1:0] MODE_PRIO = 2'd3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [SAMPLE_W-1:0]   r_cur;
    logic [SAMPLE_W-1:0]   r_nxt;
    logic                  r_nxt_valid;
    logic [BC_W-1:0]       r_burst_cnt;
    logic                  r_active_src;
    logic [CNT_W-1:0]      r_underrun_cnt;
    logic [1:0]            r_mode_q;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_cur_elig;
    logic                  w_oth_elig;
    logic                  w_mode_chg;
    logic [BC_W-1:0]       w_cnt_eff;
    logic [BC_W-1:0]       w_cnt_inc;
    logic                  w_grant_vld;
    logic                  w_grant_src;
    logic                  w_burst_clr;
    logic                  w_slot_free;
    logic                  w_grant_go;
    logic                  w_fill_go;
    logic                  w_consume;

    assign w_elig0    = ~i_src0_empty;
    assign w_elig1    = ~i_src1_empty;
    assign w_cur_elig = r_active_src ? w_elig1 : w_elig0;
    assign w_oth_elig = r_active_src ? w_elig0 : w_elig1;

    // A mode change restarts the burst count; the arbiter must already see
    // the cleared count in the same cycle the new mode first appears.
    assign w_mode_chg = (i_mode != r_mode_q);
    assign w_cnt_eff  = w_mode_chg ? '0 : r_burst_cnt;
    assign w_cnt_inc  = (w_cnt_eff == LP_BURST) ? w_cnt_eff : w_cnt_eff + BC_W'(1);

    assign w_consume   = i_mod_read & r_nxt_valid;
    // nxt_valid=0 already excludes a consume in the same cycle.
    assign w_slot_free = (r_state == ST_IDLE) & i_enable & ~r_nxt_valid;
    assign w_grant_go  = w_slot_free & w_grant_vld;
    assign w_fill_go   = w_slot_free & ~w_grant_vld & i_fill_en;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_src = r_active_src;
        w_burst_clr = 1'b0;
        case (i_mode)
            MODE_SRC0: begin
                if (w_elig0) begin
                    w_grant_vld = 1'b1;
                    w_grant_src = 1'b0;
                end
            end
            MODE_SRC1: begin
                if (w_elig1) begin
                    w_grant_vld = 1'b1;
                    w_grant_src = 1'b1;
                end
            end
            MODE_PRIO: begin
                if (w_elig0) begin
                    w_grant_vld = 1'b1;
                    w_grant_src = 1'b0;
                end else if (w_elig1) begin
                    w_grant_vld = 1'b1;
                    w_grant_src = 1'b1;
                end
            end
            MODE_RR: begin
                if (w_cur_elig && (w_cnt_eff < LP_BURST)) begin
                    w_grant_vld = 1'b1;
                    w_grant_src = r_active_src;
                end else if (w_oth_elig) begin
                    w_grant_vld = 1'b1;
                    w_grant_src = ~r_active_src;
                    w_burst_clr = 1'b1;
                end else if (w_cur_elig) begin
                    // burst exhausted but nobody else wants the slot
                    w_grant_vld = 1'b1;
                    w_grant_src = r_active_src;
                    w_burst_clr = 1'b1;
                end
            end
            default: begin
                w_grant_vld = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The read strobes are decoded from ST_IDLE so the FIFO pops on the grant
    // edge and its data is valid during ST_CAPTURE. They are gated with the
    // reset so a FIFO never sees a strobe while the block is held in reset.
    always_comb begin
        w_state_nxt = r_state;
        o_src0_read = 1'b0;
        o_src1_read = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_go) begin
                    w_state_nxt = ST_CAPTURE;
                    o_src0_read = ~w_grant_src & i_rst_n;
                    o_src1_read = w_grant_src & i_rst_n;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sample storage, burst tracking, underrun counter
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur          <= LP_IDLE;
            r_nxt          <= LP_IDLE;
            r_nxt_valid    <= 1'b0;
            r_burst_cnt    <= '0;
            r_active_src   <= 1'b0;
            r_underrun_cnt <= '0;
            r_mode_q       <= 2'd0;
        end else begin
            r_mode_q <= i_mode;

            if (r_state == ST_CAPTURE) begin
                r_burst_cnt <= w_cnt_inc;
            end else if (w_grant_go && w_burst_clr) begin
                r_burst_cnt <= '0;
            end else begin
                r_burst_cnt <= w_cnt_eff;
            end

            if (w_grant_go) begin
                r_active_src <= w_grant_src;
            end

            // Capture and consume never coincide: capture only follows a
            // grant, which requires the prefetch slot to be empty.
            if (w_consume) begin
                r_cur       <= r_nxt;
                r_nxt_valid <= 1'b0;
            end else if (r_state == ST_CAPTURE) begin
                r_nxt       <= r_active_src ? i_src1_data : i_src0_data;
                r_nxt_valid <= 1'b1;
            end else if (w_fill_go) begin
                r_nxt       <= LP_IDLE;
                r_nxt_valid <= 1'b1;
                if (r_underrun_cnt != '1) begin
                    r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_mod_sample   = r_cur;
    assign o_mod_empty    = ~r_nxt_valid;
    assign o_active_src   = r_active_src;
    assign o_underrun_cnt = r_underrun_cnt;
    assign o_busy         = (r_state == ST_CAPTURE) | r_nxt_valid;

endmodule

// File: tb/tb_mod_sample_sched.sv
// -----------------------------------------------------------------------------
// tb_mod_sample_sched
//
// Bench for mod_sample_sched (BURST_LEN=4, CNT_W=2). Two behavioural FIFOs
// feed the scheduler; every read strobe is logged as a grant (0/1) so grant
// order can be compared against hand-computed patterns. Inputs are driven
// 1 time unit after the rising edge, outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_mod_sample_sched;

    localparam int SW = 8;
    localparam int BL = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          fill_en = 1'b0;
    logic          mod_read = 1'b0;
    logic [SW-1:0] src0_data = '0;
    logic [SW-1:0] src1_data = '0;
    logic          src0_empty, src1_empty, src0_read, src1_read;
    logic [SW-1:0] mod_sample;
    logic          mod_empty, active_src, busy;
    logic [CW-1:0] underrun_cnt;

    logic [SW-1:0] mem0 [0:63];
    logic [SW-1:0] mem1 [0:63];
    int            wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    logic          clr = 1'b1;
    logic          pend0 = 1'b0, pend1 = 1'b0;
    int            glog [0:63];
    int            nlog = 0;
    int            both_err = 0;

    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    assign src0_empty = (wr0 == rd0);
    assign src1_empty = (wr1 == rd1);

    mod_sample_sched #(
        .SAMPLE_W   (SW),
        .BURST_LEN  (BL),
        .IDLE_SAMPLE(128),
        .CNT_W      (CW)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_mode        (mode),
        .i_fill_en     (fill_en),
        .i_src0_data   (src0_data),
        .i_src0_empty  (src0_empty),
        .o_src0_read   (src0_read),
        .i_src1_data   (src1_data),
        .i_src1_empty  (src1_empty),
        .o_src1_read   (src1_read),
        .o_mod_sample  (mod_sample),
        .o_mod_empty   (mod_empty),
        .i_mod_read    (mod_read),
        .o_active_src  (active_src),
        .o_underrun_cnt(underrun_cnt),
        .o_busy        (busy)
    );

    // Read strobes are sampled mid-cycle, then acted on at the next edge.
    always @(negedge clk) begin
        pend0 <= src0_read;
        pend1 <= src1_read;
    end

    always @(posedge clk) begin
        if (clr) begin
            rd0      <= 0;
            rd1      <= 0;
            nlog     <= 0;
            both_err <= 0;
        end else begin
            if (pend0 && pend1) both_err <= both_err + 1;
            if (pend0) begin
                src0_data <= mem0[rd0];
                rd0       <= rd0 + 1;
                if (nlog < 64) glog[nlog] <= 0;
                nlog      <= nlog + 1;
            end else if (pend1) begin
                src1_data <= mem1[rd1];
                rd1       <= rd1 + 1;
                if (nlog < 64) glog[nlog] <= 1;
                nlog      <= nlog + 1;
            end
        end
    end

    typedef struct {
        logic [1:0] mode;
        int         n0;
        int         n1;
        int         exp_n;
        int         exp_pat;
    } vec_t;

    vec_t vt [0:6];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [SW-1:0] v);
        mem0[wr0] = v;
        wr0++;
    endtask

    task automatic push1(input logic [SW-1:0] v);
        mem1[wr1] = v;
        wr1++;
    endtask

    task automatic reset_all();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        clr      = 1'b1;
        enable   = 1'b0;
        fill_en  = 1'b0;
        mod_read = 1'b0;
        mode     = 2'd0;
        wr0      = 0;
        wr1      = 0;
        @(posedge clk);
        #1;
        clr   = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic consume_pulse();
        @(posedge clk);
        #1;
        mod_read = 1'b1;
        @(posedge clk);
        #1;
        mod_read = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (nlog < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (nlog < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout, got %0d grants expected %0d", name, nlog, n);
        end
    endtask

    function automatic int log_pat(input int n);
        int p;
        p = 0;
        for (int i = 0; i < n && i < 32; i++) begin
            if (glog[i] != 0) p = p | (1 << i);
        end
        return p;
    endfunction

    initial begin
        int glitch;

        vt[0] = '{2'd0,  5,  5,  5, 32'h0000_0000};
        vt[1] = '{2'd1,  5,  5,  5, 32'h0000_001F};
        vt[2] = '{2'd2, 12, 12, 24, 32'h00F0_F0F0};
        vt[3] = '{2'd3,  3,  3,  6, 32'h0000_0038};
        vt[4] = '{2'd2,  6,  0,  6, 32'h0000_0000};
        vt[5] = '{2'd2,  2,  5,  7, 32'h0000_007C};
        vt[6] = '{2'd1,  5,  0,  0, 32'h0000_0000};

        // ---- reset state, held in reset with a source ready ----
        enable = 1'b1;
        push0(8'h42);
        tick(3);
        @(negedge clk);
        chk("rst mod_sample", int'(mod_sample), 128);
        chk("rst mod_empty", int'(mod_empty), 1);
        chk("rst src0_read", int'(src0_read), 0);
        chk("rst src1_read", int'(src1_read), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst active_src", int'(active_src), 0);
        chk("rst underrun", int'(underrun_cnt), 0);

        // ---- mode 0, slow consumer, sample held across the symbol ----
        reset_all();
        push0(8'h10);
        push0(8'h20);
        push0(8'h30);
        mode   = 2'd0;
        enable = 1'b1;
        tick(6);
        @(negedge clk);
        chk("m0 before consume", int'(mod_sample), 128);
        chk("m0 prefetch valid", int'(mod_empty), 0);
        chk("m0 busy", int'(busy), 1);
        for (int s = 0; s < 3; s++) begin
            consume_pulse();
            @(negedge clk);
            chk($sformatf("m0 step%0d", s), int'(mod_sample), 16 * (s + 1));
            glitch = 0;
            for (int c = 0; c < 255; c++) begin
                @(negedge clk);
                if (mod_sample != 8'(16 * (s + 1))) glitch++;
            end
            chk($sformatf("m0 hold%0d", s), glitch, 0);
        end
        chk("m0 drained", int'(mod_empty), 1);
        chk("m0 read count", nlog, 3);
        chk("m0 no src1", log_pat(nlog), 0);
        consume_pulse();
        @(negedge clk);
        chk("m0 read on empty ignored", int'(mod_sample), 8'h30);

        // ---- table: grant order under fast consumption ----
        for (int v = 0; v < 7; v++) begin
            reset_all();
            mode = vt[v].mode;
            for (int i = 0; i < vt[v].n0; i++) push0(8'(i + 1));
            for (int i = 0; i < vt[v].n1; i++) push1(8'(8'h80 + i));
            enable   = 1'b1;
            mod_read = 1'b1;
            tick(150);
            chk($sformatf("vec%0d grant count", v), nlog, vt[v].exp_n);
            chk($sformatf("vec%0d grant order", v), log_pat(nlog), vt[v].exp_pat);
            chk($sformatf("vec%0d dual read", v), both_err, 0);
        end

        // ---- mode 2, src1 arrives mid-burst: switch only at boundary ----
        reset_all();
        mode = 2'd2;
        for (int i = 0; i < 10; i++) push0(8'(i + 1));
        enable   = 1'b1;
        mod_read = 1'b1;
        wait_log(2, 60, "rr mid-burst start");
        @(posedge clk);
        #1;
        push1(8'hB0);
        push1(8'hB1);
        push1(8'hB2);
        wait_log(13, 300, "rr mid-burst run");
        tick(20);
        chk("rr mid-burst count", nlog, 13);
        chk("rr mid-burst order", log_pat(nlog), 32'h70);

        // ---- fill on underrun, saturating counter ----
        reset_all();
        mode    = 2'd0;
        fill_en = 1'b1;
        enable  = 1'b1;
        tick(3);
        @(negedge clk);
        chk("fill first count", int'(underrun_cnt), 1);
        chk("fill prefetch", int'(mod_empty), 0);
        chk("fill sample", int'(mod_sample), 128);
        for (int k = 0; k < 4; k++) begin
            consume_pulse();
            tick(3);
            @(negedge clk);
            chk($sformatf("fill%0d sample", k), int'(mod_sample), 128);
            chk($sformatf("fill%0d count", k), int'(underrun_cnt), (k + 2 > 3) ? 3 : k + 2);
        end

        // ---- reset in the middle of a capture ----
        @(posedge clk);
        #1;
        fill_en = 1'b0;
        consume_pulse();
        @(posedge clk);
        #1;
        clr = 1'b1;
        wr0 = 0;
        wr1 = 0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        push0(8'h11);
        push0(8'h22);
        wait_log(1, 20, "midcap fetch");
        chk("midcap busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midcap mod_sample", int'(mod_sample), 128);
        chk("midcap mod_empty", int'(mod_empty), 1);
        chk("midcap src0_read", int'(src0_read), 0);
        chk("midcap src1_read", int'(src1_read), 0);
        chk("midcap underrun", int'(underrun_cnt), 0);
        chk("midcap busy cleared", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_log(2, 20, "midcap refetch");
        tick(4);
        consume_pulse();
        @(negedge clk);
        chk("midcap next sample", int'(mod_sample), 8'h22);
        chk("midcap read count", nlog, 2);

        // ---- mode 3: src0 appears while src1 is being captured ----
        reset_all();
        mode = 2'd3;
        push1(8'hA1);
        push1(8'hA2);
        enable = 1'b1;
        wait_log(1, 20, "prio first grant");
        chk("prio first src", glog[0], 1);
        #1;
        push0(8'h55);
        tick(4);
        @(negedge clk);
        chk("prio held", int'(mod_sample), 128);
        chk("prio active src1", int'(active_src), 1);
        chk("prio one grant", nlog, 1);
        consume_pulse();
        @(negedge clk);
        chk("prio src1 sample", int'(mod_sample), 8'hA1);
        wait_log(2, 20, "prio second grant");
        chk("prio second src", glog[1], 0);
        chk("prio active src0", int'(active_src), 0);
        tick(4);
        enable = 1'b0;
        consume_pulse();
        @(negedge clk);
        chk("dis prefetched consumed", int'(mod_sample), 8'h55);
        tick(20);
        @(negedge clk);
        chk("dis no reads", nlog, 2);
        chk("dis mod_empty", int'(mod_empty), 1);
        chk("dis busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
